// File: rtl/fp_dsp_pkg.sv
// Shared floating-point DSP definitions: data width, opcodes, default FPU
// latency and a small index-width helper.
package fp_dsp_pkg;

  localparam int unsigned FP_DW   = 32;
  localparam int unsigned FP_OPW  = 3;
  localparam int unsigned FPU_LAT = 3;

  typedef enum logic [FP_OPW-1:0] {
    FOP_ADD = 3'd0,
    FOP_SUB = 3'd1,
    FOP_MUL = 3'd2,
    FOP_MAC = 3'd3,
    FOP_CMP = 3'd4,
    FOP_CVT = 3'd5
  } fop_e;

  // Width needed to hold an index into n entries (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_issue_arbiter_if.sv
// Request, FPU issue/result and response bundle of the FPU issue arbiter.
// master: arbiter side; slave: requesters plus FPU side.
interface fpu_issue_arbiter_if import fp_dsp_pkg::*; #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = FP_DW,
  parameter int unsigned OPW  = FP_OPW
) ();

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_op;
  logic [NREQ*DW-1:0]  req_a;
  logic [NREQ*DW-1:0]  req_b;

  logic                fpu_valid;
  logic [OPW-1:0]      fpu_op;
  logic [DW-1:0]       fpu_a;
  logic [DW-1:0]       fpu_b;
  logic                fpu_flush;
  logic                fpu_res_valid;
  logic [DW-1:0]       fpu_res;

  logic [NREQ-1:0]     rsp_valid;
  logic [DW-1:0]       rsp_data;

  modport master (
    input  req_valid, req_op, req_a, req_b, fpu_res_valid, fpu_res,
    output req_ready, fpu_valid, fpu_op, fpu_a, fpu_b, fpu_flush,
           rsp_valid, rsp_data
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, fpu_res_valid, fpu_res,
    input  req_ready, fpu_valid, fpu_op, fpu_a, fpu_b, fpu_flush,
           rsp_valid, rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans requests from ptr upward with
// wrap-around and grants the first active one when enabled.
module rr_arbiter import fp_dsp_pkg::*; #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW:0] pos;
  logic        found;

  // First active requester at or after ptr, wrapping past NREQ-1 to 0.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NREQ)) pos = pos - (IW+1)'(NREQ);
      if (en && !found && req[pos[IW-1:0]]) begin
        found              = 1'b1;
        gnt[pos[IW-1:0]]   = 1'b1;
        idx                = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one pipelined FPU between NREQ requesters: round-robin issue into a
// registered FPU port, owner tracking per in-flight op, result steering back
// to the issuer, and a sticky flag for results arriving out of turn.
module fpu_issue_arbiter import fp_dsp_pkg::*; #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned LAT  = FPU_LAT,
  parameter int unsigned DW   = FP_DW,
  parameter int unsigned OPW  = FP_OPW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  fpu_issue_arbiter_if.master        bus,
  output logic [$clog2(LAT+2)-1:0]   inflight,
  output logic                       busy,
  output logic                       err
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned CW = $clog2(LAT+2);

  logic [IW-1:0]          ptr_q, ptr_d;
  logic                   arb_en;
  logic [NREQ-1:0]        gnt;
  logic [IW-1:0]          win;
  logic                   accept;

  logic                   fpu_valid_q, fpu_valid_d;
  logic [IW-1:0]          fpu_owner_q, fpu_owner_d;
  logic [OPW-1:0]         fpu_op_q, fpu_op_d;
  logic [DW-1:0]          fpu_a_q, fpu_a_d;
  logic [DW-1:0]          fpu_b_q, fpu_b_d;
  logic                   fpu_flush_q, fpu_flush_d;

  logic [LAT-1:0]          tag_vld_q, tag_vld_d;
  logic [LAT-1:0][IW-1:0]  tag_own_q, tag_own_d;

  logic                   exp_valid;
  logic [IW-1:0]          exp_owner;
  logic                   res_match;
  logic                   res_mismatch;

  logic [CW-1:0]          inflight_q, inflight_d;
  logic                   err_q, err_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt),
    .idx (win)
  );

  // Issue gating and result matching against the expected-owner tag.
  always_comb begin
    arb_en        = reset & ~stall & ~flush;
    accept        = |gnt;
    bus.req_ready = gnt;
    exp_valid     = tag_vld_q[LAT-1];
    exp_owner     = tag_own_q[LAT-1];
    res_match     = bus.fpu_res_valid & exp_valid;
    res_mismatch  = bus.fpu_res_valid ^ exp_valid;
    bus.rsp_valid = '0;
    if (res_match) bus.rsp_valid[exp_owner] = 1'b1;
    bus.rsp_data  = bus.fpu_res;
  end

  // Next-state: pointer, issue register, tag shift chain, counters, error.
  // The tag chain is fed from the issue register rather than the accept, so
  // the last of LAT stages lines up with results LAT cycles after fpu_valid.
  always_comb begin
    ptr_d       = ptr_q;
    fpu_valid_d = 1'b0;
    fpu_owner_d = fpu_owner_q;
    fpu_op_d    = fpu_op_q;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    fpu_flush_d = flush;
    tag_vld_d   = '0;
    tag_own_d   = tag_own_q;
    inflight_d  = inflight_q;
    err_d       = err_q | res_mismatch;

    if (accept) begin
      ptr_d       = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
      fpu_valid_d = 1'b1;
      fpu_owner_d = win;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (win == IW'(i)) begin
          fpu_op_d = bus.req_op[i*OPW +: OPW];
          fpu_a_d  = bus.req_a[i*DW +: DW];
          fpu_b_d  = bus.req_b[i*DW +: DW];
        end
      end
    end

    tag_vld_d[0] = fpu_valid_q;
    tag_own_d[0] = fpu_owner_q;
    for (int unsigned k = 1; k < LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_own_d[k] = tag_own_q[k-1];
    end

    inflight_d = inflight_q + CW'(accept) - CW'(res_match);

    if (flush) begin
      fpu_valid_d = 1'b0;
      tag_vld_d   = '0;
      inflight_d  = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      fpu_valid_q <= 1'b0;
      fpu_owner_q <= '0;
      fpu_op_q    <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_flush_q <= 1'b0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
      inflight_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      fpu_valid_q <= fpu_valid_d;
      fpu_owner_q <= fpu_owner_d;
      fpu_op_q    <= fpu_op_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_flush_q <= fpu_flush_d;
      tag_vld_q   <= tag_vld_d;
      tag_own_q   <= tag_own_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  // Registered outputs.
  always_comb begin
    bus.fpu_valid = fpu_valid_q;
    bus.fpu_op    = fpu_op_q;
    bus.fpu_a     = fpu_a_q;
    bus.fpu_b     = fpu_b_q;
    bus.fpu_flush = fpu_flush_q;
    inflight      = inflight_q;
    busy          = (inflight_q != '0);
    err           = err_q;
  end

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Bench for fpu_issue_arbiter: per-cycle vector table for arbitration,
// stall, response steering and occupancy, plus directed sequences for the
// single-op latency, flush, spurious-result error and mid-burst reset.
module tb_fpu_issue_arbiter;
  import fp_dsp_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned LAT  = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned OPW  = 3;
  localparam int unsigned NVEC = 24;

  logic clk = 1'b0;
  logic reset;
  logic stall;
  logic flush;
  logic [$clog2(LAT+2)-1:0] inflight;
  logic busy;
  logic err;

  int checks   = 0;
  int failures = 0;
  int cyc;
  logic [1:0] seen;

  always #5 clk = ~clk;

  fpu_issue_arbiter_if #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) bus ();

  fpu_issue_arbiter #(.NREQ(NREQ), .LAT(LAT), .DW(DW), .OPW(OPW)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .flush    (flush),
    .bus      (bus),
    .inflight (inflight),
    .busy     (busy),
    .err      (err)
  );

  // Stand-in FPU: known answer for 1.0+2.0, otherwise a scrambling function.
  function automatic logic [31:0] fpu_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    if (op == FOP_ADD && a == 32'h3F800000 && b == 32'h40000000)
      return 32'h40400000;
    return a ^ {b[15:0], b[31:16]} ^ {29'd0, op};
  endfunction

  // FPU pipeline model of depth LAT; drops its contents on fpu_flush.
  logic [LAT-1:0] m_v;
  logic [31:0]    m_d [LAT];
  logic           inject;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_v <= '0;
    end else if (bus.fpu_flush) begin
      m_v <= '0;
    end else begin
      m_v    <= {m_v[LAT-2:0], bus.fpu_valid};
      m_d[0] <= fpu_model(bus.fpu_op, bus.fpu_a, bus.fpu_b);
      for (int k = 1; k < LAT; k++) m_d[k] <= m_d[k-1];
    end
  end

  assign bus.fpu_res_valid = (m_v[LAT-1] & ~bus.fpu_flush) | inject;
  assign bus.fpu_res       = m_d[LAT-1];

  typedef struct {
    logic       stall;
    logic       flush;
    logic [1:0] rv;
    logic [1:0] ready;
    logic       fv;
    logic [1:0] rsp;
    logic [2:0] infl;
  } vec_t;

  vec_t tbl [NVEC];

  logic [2:0]  r_op [NREQ];
  logic [31:0] r_a  [NREQ];
  logic [31:0] r_b  [NREQ];

  function automatic vec_t mk(input logic s, input logic f, input logic [1:0] rv,
                              input logic [1:0] rdy, input logic fv,
                              input logic [1:0] rsp, input logic [2:0] infl);
    vec_t v;
    v.stall = s; v.flush = f; v.rv = rv; v.ready = rdy;
    v.fv = fv; v.rsp = rsp; v.infl = infl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    r_op[i] = op; r_a[i] = a; r_b[i] = b;
    bus.req_op[i*OPW +: OPW] = op;
    bus.req_a[i*DW +: DW]    = a;
    bus.req_b[i*DW +: DW]    = b;
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; inject = 1'b0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            stall flush rv     ready  fv    rsp    inflight
    tbl[0]  = mk(1'b0, 1'b0, 2'b11, 2'b01, 1'b0, 2'b00, 3'd0);
    tbl[1]  = mk(1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 2'b00, 3'd1);
    tbl[2]  = mk(1'b0, 1'b0, 2'b11, 2'b01, 1'b1, 2'b00, 3'd2);
    tbl[3]  = mk(1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 2'b00, 3'd3);
    tbl[4]  = mk(1'b0, 1'b0, 2'b11, 2'b01, 1'b1, 2'b01, 3'd4);
    tbl[5]  = mk(1'b0, 1'b0, 2'b11, 2'b10, 1'b1, 2'b10, 3'd4);
    tbl[6]  = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 3'd4);
    tbl[7]  = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 3'd3);
    tbl[8]  = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 3'd2);
    tbl[9]  = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 3'd1);
    tbl[10] = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3'd0);
    tbl[11] = mk(1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 3'd0);
    tbl[12] = mk(1'b1, 1'b0, 2'b11, 2'b00, 1'b1, 2'b00, 3'd1);
    tbl[13] = mk(1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 3'd1);
    tbl[14] = mk(1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 3'd1);
    tbl[15] = mk(1'b0, 1'b0, 2'b11, 2'b10, 1'b0, 2'b01, 3'd1);
    tbl[16] = mk(1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 2'b00, 3'd1);
    tbl[17] = mk(1'b0, 1'b0, 2'b10, 2'b10, 1'b1, 2'b00, 3'd2);
    tbl[18] = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 3'd3);
    tbl[19] = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 3'd3);
    tbl[20] = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 3'd2);
    tbl[21] = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 3'd1);
    tbl[22] = mk(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 3'd0);
    tbl[23] = mk(1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 2'b00, 3'd0);

    reset = 1'b0; stall = 1'b0; flush = 1'b0; inject = 1'b0;
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;

    // Single ADD from requester 0: issue, latency, steering, drain.
    do_reset();
    set_req(0, FOP_ADD, 32'h3F800000, 32'h40000000);
    set_req(1, FOP_MUL, 32'h12345678, 32'h9ABCDEF0);
    bus.req_valid = 2'b01;
    sample();
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    chk("t1_inflight_reset", 32'(inflight), 32'h0);
    chk("t1_fpu_valid_reset", 32'(bus.fpu_valid), 32'h0);
    step();
    bus.req_valid = 2'b00;
    sample();
    chk("t1_fpu_valid", 32'(bus.fpu_valid), 32'h1);
    chk("t1_fpu_op", 32'(bus.fpu_op), 32'(FOP_ADD));
    chk("t1_fpu_a", bus.fpu_a, 32'h3F800000);
    chk("t1_fpu_b", bus.fpu_b, 32'h40000000);
    chk("t1_inflight1", 32'(inflight), 32'h1);
    cyc = 1;
    while (bus.rsp_valid == 2'b00 && cyc < 12) begin
      step(); sample(); cyc++;
    end
    chk("t1_rsp_cycle", 32'(cyc), 32'(1 + LAT));
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_data", bus.rsp_data, 32'h40400000);
    step(); sample();
    chk("t1_inflight0", 32'(inflight), 32'h0);
    chk("t1_busy0", 32'(busy), 32'h0);
    chk("t1_err", 32'(err), 32'h0);
    step();

    // Vector table: alternation, drain order, stall hold, single requester.
    do_reset();
    set_req(0, FOP_SUB, 32'h11110001, 32'h0000AAAA);
    set_req(1, FOP_MUL, 32'h22220002, 32'h0000BBBB);
    for (int i = 0; i < int'(NVEC); i++) begin
      stall = tbl[i].stall;
      flush = tbl[i].flush;
      bus.req_valid = tbl[i].rv;
      sample();
      chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
      chk($sformatf("v%0d_fpu_valid", i), 32'(bus.fpu_valid), 32'(tbl[i].fv));
      chk($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].rsp));
      chk($sformatf("v%0d_inflight", i), 32'(inflight), 32'(tbl[i].infl));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].infl != 3'd0));
      chk($sformatf("v%0d_err", i), 32'(err), 32'h0);
      if (tbl[i].rsp != 2'b00) begin
        chk($sformatf("v%0d_rsp_data", i), bus.rsp_data,
            fpu_model(r_op[tbl[i].rsp[1]], r_a[tbl[i].rsp[1]], r_b[tbl[i].rsp[1]]));
      end
      step();
    end
    stall = 1'b0; flush = 1'b0; bus.req_valid = '0;

    // Flush with three ops outstanding.
    do_reset();
    set_req(0, FOP_MAC, 32'h33330003, 32'h0000CCCC);
    bus.req_valid = 2'b01;
    step(); step(); step();
    flush = 1'b1;
    sample();
    chk("fl_ready", 32'(bus.req_ready), 32'h0);
    chk("fl_inflight_before", 32'(inflight), 32'h3);
    step();
    flush = 1'b0;
    bus.req_valid = 2'b00;
    sample();
    chk("fl_fpu_flush", 32'(bus.fpu_flush), 32'h1);
    chk("fl_inflight_after", 32'(inflight), 32'h0);
    chk("fl_fpu_valid", 32'(bus.fpu_valid), 32'h0);
    chk("fl_busy", 32'(busy), 32'h0);
    seen = bus.rsp_valid;
    step(); sample();
    chk("fl_fpu_flush_pulse", 32'(bus.fpu_flush), 32'h0);
    repeat (6) begin
      seen = seen | bus.rsp_valid;
      step(); sample();
    end
    chk("fl_no_rsp", 32'(seen), 32'h0);
    chk("fl_err", 32'(err), 32'h0);
    step();

    // Spurious FPU result: sticky error, response suppressed.
    do_reset();
    inject = 1'b1;
    sample();
    chk("er_rsp_suppressed", 32'(bus.rsp_valid), 32'h0);
    chk("er_err_before_edge", 32'(err), 32'h0);
    step();
    inject = 1'b0;
    sample();
    chk("er_err_set", 32'(err), 32'h1);
    repeat (4) step();
    sample();
    chk("er_err_sticky", 32'(err), 32'h1);
    #1;
    reset = 1'b0;
    #1;
    chk("er_err_reset", 32'(err), 32'h0);
    step();

    // Reset mid-burst with two ops in flight and the pointer at 1.
    do_reset();
    set_req(0, FOP_ADD, 32'h44440004, 32'h0000DDDD);
    set_req(1, FOP_SUB, 32'h55550005, 32'h0000EEEE);
    bus.req_valid = 2'b01;
    step(); step();
    bus.req_valid = 2'b11;
    #2;
    reset = 1'b0;
    #1;
    chk("rs_fpu_valid", 32'(bus.fpu_valid), 32'h0);
    chk("rs_fpu_op", 32'(bus.fpu_op), 32'h0);
    chk("rs_fpu_a", bus.fpu_a, 32'h0);
    chk("rs_fpu_b", bus.fpu_b, 32'h0);
    chk("rs_fpu_flush", 32'(bus.fpu_flush), 32'h0);
    chk("rs_inflight", 32'(inflight), 32'h0);
    chk("rs_busy", 32'(busy), 32'h0);
    chk("rs_err", 32'(err), 32'h0);
    chk("rs_ready", 32'(bus.req_ready), 32'h0);
    chk("rs_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sample();
    chk("rs_first_grant", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 2'b00;
    seen = 2'b00;
    repeat (LAT + 3) begin
      step(); sample();
      seen = seen | bus.rsp_valid;
    end
    chk("rs_no_stale_rsp", 32'(seen), 32'h0);
    chk("rs_err_after", 32'(err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
